// File: rtl/angle_pwm_ctrl_p.sv
// Closed-loop steering angle controller: shortest-path error, ramped PWM
// ratio via a valid/done handshake, overshoot reversal, abort and stall fault.
module angle_pwm_ctrl_p #(
  parameter int ANGLE_W    = 12,
  parameter int PWM_W      = 8,
  parameter int TOLERANCE  = 4,
  parameter int DECEL_ZONE = 256,
  parameter int RAMP_STEP  = 8,
  parameter int MIN_POWER  = 16,
  parameter int STALL_W    = 24
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ANGLE_W-1:0] target_angle,
  input  logic               angle_update,
  input  logic               abort_angle,
  input  logic [ANGLE_W-1:0] current_angle,
  input  logic               current_valid,
  input  logic [PWM_W-1:0]   cruise_power,
  input  logic               enable_stall_chk,
  input  logic [STALL_W-1:0] stall_timeout,
  input  logic               pwm_done,
  output logic               pwm_update,
  output logic [PWM_W-1:0]   pwm_ratio,
  output logic               pwm_direction,
  output logic               angle_done,
  output logic               stall_fault,
  output logic               busy
);

  localparam logic [ANGLE_W-1:0] TOL_C  = ANGLE_W'(TOLERANCE);
  localparam logic [ANGLE_W-1:0] DZ_C   = ANGLE_W'(DECEL_ZONE);
  localparam logic [PWM_W-1:0]   MIN_C  = PWM_W'(MIN_POWER);
  localparam logic [PWM_W-1:0]   STEP_C = PWM_W'(RAMP_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_STOP
  } state_t;

  state_t             state;
  logic [ANGLE_W-1:0] tgt;
  logic [ANGLE_W-1:0] prev_mag;
  logic [STALL_W-1:0] stall_cnt;
  logic               zero_sent;
  logic               quiet;

  logic [ANGLE_W-1:0] diff;
  logic               err_dir;
  logic [ANGLE_W-1:0] err_mag;
  logic [PWM_W:0]     up_sum;
  logic [PWM_W:0]     dn_floor;
  logic [PWM_W-1:0]   up_ratio;
  logic [PWM_W-1:0]   dn_ratio;
  logic               stall_on;
  logic               improved;
  logic               stall_hit;
  logic               step_go;

  always_comb begin
    diff     = tgt - current_angle;
    err_dir  = ~diff[ANGLE_W-1];
    err_mag  = diff[ANGLE_W-1] ? (ANGLE_W'(0) - diff) : diff;
    up_sum   = {1'b0, pwm_ratio} + {1'b0, STEP_C};
    dn_floor = {1'b0, MIN_C} + {1'b0, STEP_C};
    up_ratio = (up_sum >= {1'b0, cruise_power}) ?
               cruise_power : up_sum[PWM_W-1:0];
    dn_ratio = ({1'b0, pwm_ratio} < dn_floor) ?
               MIN_C : (pwm_ratio - STEP_C);
    stall_on  = enable_stall_chk && (stall_timeout != '0);
    improved  = current_valid && (err_mag < prev_mag);
    stall_hit = stall_on && !improved &&
                (stall_cnt == stall_timeout);
    step_go   = current_valid && !pwm_update;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      tgt           <= '0;
      prev_mag      <= '0;
      stall_cnt     <= '0;
      zero_sent     <= 1'b0;
      quiet         <= 1'b0;
      pwm_update    <= 1'b0;
      pwm_ratio     <= '0;
      pwm_direction <= 1'b0;
      angle_done    <= 1'b0;
      stall_fault   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      angle_done <= 1'b0;
      if (pwm_update && pwm_done)
        pwm_update <= 1'b0;

      unique case (state)
        S_IDLE: begin
          zero_sent <= 1'b0;
          quiet     <= 1'b0;
          if (angle_update) begin
            tgt         <= target_angle;
            stall_fault <= 1'b0;
            busy        <= 1'b1;
            state       <= S_EVAL;
          end
        end

        S_EVAL: begin
          prev_mag  <= err_mag;
          stall_cnt <= '0;
          if (abort_angle) begin
            quiet      <= 1'b1;
            pwm_ratio  <= '0;
            pwm_update <= 1'b1;
            zero_sent  <= 1'b1;
            state      <= S_STOP;
          end else if (err_mag <= TOL_C) begin
            angle_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            pwm_direction <= err_dir;
            pwm_ratio     <= MIN_C;
            pwm_update    <= 1'b1;
            state         <= S_ACCEL;
          end
        end

        S_ACCEL, S_CRUISE, S_DECEL: begin
          if (current_valid)
            prev_mag <= err_mag;
          if (!stall_on || improved)
            stall_cnt <= '0;
          else if (!stall_hit)
            stall_cnt <= stall_cnt + 1'b1;

          if (abort_angle || stall_hit) begin
            // a pending handshake must finish before ratio 0 goes out
            quiet <= 1'b1;
            if (stall_hit && !abort_angle)
              stall_fault <= 1'b1;
            state <= S_STOP;
            if (!pwm_update) begin
              pwm_ratio  <= '0;
              pwm_update <= 1'b1;
              zero_sent  <= 1'b1;
            end else begin
              zero_sent <= 1'b0;
            end
          end else begin
            if (angle_update)
              tgt <= target_angle;
            if (step_go) begin
              if (err_mag <= TOL_C) begin
                pwm_ratio  <= '0;
                pwm_update <= 1'b1;
                zero_sent  <= 1'b1;
                quiet      <= 1'b0;
                state      <= S_STOP;
              end else if (err_dir != pwm_direction) begin
                pwm_direction <= err_dir;
                pwm_ratio     <= MIN_C;
                pwm_update    <= 1'b1;
                state         <= S_ACCEL;
              end else if (err_mag < DZ_C) begin
                pwm_ratio  <= dn_ratio;
                pwm_update <= (dn_ratio != pwm_ratio);
                state      <= S_DECEL;
              end else begin
                pwm_ratio  <= up_ratio;
                pwm_update <= (up_ratio != pwm_ratio);
                state      <= (up_ratio == cruise_power) ?
                              S_CRUISE : S_ACCEL;
              end
            end
          end
        end

        S_STOP: begin
          if (angle_update)
            tgt <= target_angle;
          if (!pwm_update && !zero_sent) begin
            pwm_ratio  <= '0;
            pwm_update <= 1'b1;
            zero_sent  <= 1'b1;
          end else if (pwm_update && pwm_done && zero_sent) begin
            angle_done <= !quiet;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_angle_pwm_ctrl_p.sv
// Randomized bench for angle_pwm_ctrl_p against a shortest-path
// angle model that predicts each ratio/direction update.
module tb_angle_pwm_ctrl_p;

  localparam int TOL   = 4;
  localparam int DZ    = 256;
  localparam int STEP  = 8;
  localparam int MINP  = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] target_angle = '0;
  logic        angle_update = 1'b0;
  logic        abort_angle = 1'b0;
  logic [11:0] current_angle = '0;
  logic        current_valid = 1'b0;
  logic [7:0]  cruise_power = 8'd40;
  logic        enable_stall_chk = 1'b0;
  logic [23:0] stall_timeout = '0;
  logic        pwm_done = 1'b0;
  logic        pwm_update;
  logic [7:0]  pwm_ratio;
  logic        pwm_direction;
  logic        angle_done;
  logic        stall_fault;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int m_ratio = 0;
  int m_dir = 0;

  angle_pwm_ctrl_p dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .target_angle     (target_angle),
    .angle_update     (angle_update),
    .abort_angle      (abort_angle),
    .current_angle    (current_angle),
    .current_valid    (current_valid),
    .cruise_power     (cruise_power),
    .enable_stall_chk (enable_stall_chk),
    .stall_timeout    (stall_timeout),
    .pwm_done         (pwm_done),
    .pwm_update       (pwm_update),
    .pwm_ratio        (pwm_ratio),
    .pwm_direction    (pwm_direction),
    .angle_done       (angle_done),
    .stall_fault      (stall_fault),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // signed shortest error, half-circle tie resolved toward decreasing
  function automatic void err_of(input int t, input int c,
                                 output int d, output int m);
    int e;
    e = t - c;
    while (e > 2047) e -= 4096;
    while (e < -2048) e += 4096;
    d = (e >= 0) ? 1 : 0;
    m = (e < 0) ? -e : e;
  endfunction

  task automatic model_step(input int mag, input int d,
                            output bit stop, output bit upd);
    int nr;
    stop = 0;
    upd  = 0;
    if (mag <= TOL) begin
      stop = 1;
      upd = 1;
      m_ratio = 0;
    end else if (d != m_dir) begin
      m_dir = d;
      m_ratio = MINP;
      upd = 1;
    end else begin
      if (mag < DZ)
        nr = (m_ratio - STEP < MINP) ? MINP : m_ratio - STEP;
      else
        nr = (m_ratio + STEP > int'(cruise_power)) ?
             int'(cruise_power) : m_ratio + STEP;
      upd = (nr != m_ratio);
      m_ratio = nr;
    end
  endtask

  task automatic ack(input int dly);
    repeat (dly) tick();
    pwm_done = 1'b1;
    tick();
    pwm_done = 1'b0;
    chk("upd_fall", pwm_update, 0);
  endtask

  task automatic start_move(input int t, input int c, output bit mv);
    int d, m;
    target_angle  = 12'(t);
    current_angle = 12'(c);
    angle_update  = 1'b1;
    tick();
    angle_update = 1'b0;
    chk("busy_eval", busy, 1);
    tick();
    err_of(t, c, d, m);
    if (m <= TOL) begin
      mv = 0;
      chk("done_now", angle_done, 1);
      chk("no_upd_now", pwm_update, 0);
      chk("idle_now", busy, 0);
    end else begin
      mv = 1;
      m_dir = d;
      m_ratio = MINP;
      chk("first_upd", pwm_update, 1);
      chk("first_ratio", pwm_ratio, MINP);
      chk("first_dir", pwm_direction, d);
    end
  endtask

  task automatic sample(input int t, input int c, input int dly,
                        output bit stopped);
    int d, m;
    bit stop, upd;
    current_angle = 12'(c);
    current_valid = 1'b1;
    tick();
    current_valid = 1'b0;
    err_of(t, c, d, m);
    model_step(m, d, stop, upd);
    stopped = stop;
    if (!upd) begin
      chk("no_upd", pwm_update, 0);
    end else begin
      chk("step_upd", pwm_update, 1);
      chk("step_ratio", pwm_ratio, m_ratio);
      chk("step_dir", pwm_direction, m_dir);
      if (dly >= 0) ack(dly);
      if (stop) begin
        chk("done", angle_done, 1);
        chk("idle", busy, 0);
      end
    end
  endtask

  task automatic abort_clean();
    abort_angle = 1'b1;
    tick();
    abort_angle = 1'b0;
    chk("abort_upd", pwm_update, 1);
    chk("abort_ratio", pwm_ratio, 0);
    ack(0);
    chk("abort_nodone", angle_done, 0);
    chk("abort_idle", busy, 0);
  endtask

  initial begin
    bit mv, st;
    int c, t, d, m, stp, n;

    repeat (2) tick();
    chk("rst_upd", pwm_update, 0);
    chk("rst_ratio", pwm_ratio, 0);
    chk("rst_dir", pwm_direction, 0);
    chk("rst_done", angle_done, 0);
    chk("rst_fault", stall_fault, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    cruise_power = 8'd40;
    start_move(23, 10, mv);
    ack(0);
    sample(23, 15, 0, st);
    sample(23, 22, 0, st);
    chk("t1_stopped", st, 1);

    start_move(4090, 5, mv);
    ack(1);
    abort_clean();
    start_move(2058, 10, mv);
    ack(0);
    abort_clean();

    start_move(1500, 0, mv);
    ack(0);
    sample(1500, 0, 2, st);
    sample(1500, 0, 0, st);
    sample(1500, 0, 1, st);
    sample(1500, 0, 0, st);
    sample(1500, 1300, 0, st);
    sample(1500, 1350, 0, st);
    sample(1500, 1400, 0, st);
    sample(1500, 1420, 0, st);
    sample(1500, 1499, 0, st);
    chk("t3_stopped", st, 1);

    start_move(1500, 0, mv);
    ack(0);
    sample(1500, 0, 0, st);
    sample(1500, 0, 0, st);
    sample(1500, 0, -1, st);
    abort_angle  = 1'b1;
    angle_update = 1'b1;
    target_angle = 12'd100;
    tick();
    abort_angle  = 1'b0;
    angle_update = 1'b0;
    chk("t4_hold_upd", pwm_update, 1);
    chk("t4_hold_ratio", pwm_ratio, 40);
    repeat (3) tick();
    ack(0);
    tick();
    chk("t4_zero_upd", pwm_update, 1);
    chk("t4_zero_ratio", pwm_ratio, 0);
    ack(0);
    chk("t4_nodone", angle_done, 0);
    chk("t4_idle", busy, 0);

    enable_stall_chk = 1'b1;
    stall_timeout = 24'd100;
    target_angle  = 12'd1000;
    current_angle = 12'd100;
    angle_update  = 1'b1;
    n = 0;
    tick();
    angle_update = 1'b0;
    n = 1;
    while (!stall_fault && n < 200) begin
      pwm_done = pwm_update;
      tick();
      n++;
    end
    pwm_done = 1'b0;
    chk("t5_fault", stall_fault, 1);
    chk("t5_window", (n >= 102 && n <= 106), 1);
    chk("t5_zero_upd", pwm_update, 1);
    chk("t5_zero_ratio", pwm_ratio, 0);
    ack(0);
    chk("t5_nodone", angle_done, 0);
    chk("t5_sticky", stall_fault, 1);
    chk("t5_idle", busy, 0);
    enable_stall_chk = 1'b0;
    start_move(500, 500, mv);
    chk("t5_cleared", stall_fault, 0);

    start_move(23, 10, mv);
    ack(0);
    sample(23, 30, 0, st);
    sample(23, 10, -1, st);
    reset_n = 1'b0;
    tick();
    chk("t6_rst_upd", pwm_update, 0);
    chk("t6_rst_ratio", pwm_ratio, 0);
    chk("t6_rst_dir", pwm_direction, 0);
    chk("t6_rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 30; k++) begin
      cruise_power = 8'($urandom_range(16, 200));
      c = int'($urandom_range(0, 4095));
      t = (c + int'($urandom_range(0, 1200)) - 600 + 4096) % 4096;
      start_move(t, c, mv);
      if (mv) ack(int'($urandom_range(0, 3)));
      for (int s = 0; s < 60 && mv; s++) begin
        err_of(t, c, d, m);
        if (m <= 70)
          stp = int'($urandom_range(m > 4 ? m - 4 : 0, m + 8));
        else
          stp = int'($urandom_range(0, 70));
        c = (c + (d != 0 ? stp : -stp) + 4096) % 4096;
        sample(t, c, int'($urandom_range(0, 3)), st);
        mv = !st;
      end
      if (mv) abort_clean();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
